// File: rtl/sfilt_seq.sv
// Sequencer for the sfilt multiply/accumulate datapath: holds the sample delay
// line and coefficient table and expands each accepted sample into one command burst.
module sfilt_seq #(
    parameter int MAXTAPS = 16,
    parameter int DW      = 32,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic          cfg_rdy,
    input  logic [AW:0]   ntaps,
    input  logic [6:0]    shift,
    output logic          f_push,
    output logic [1:0]    f_cmd,
    output logic [DW-1:0] f_q,
    output logic [DW-1:0] f_h,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, MAC, SHIFT, FLUSH} state_e;

    localparam logic [1:0]  CMD_MULT  = 2'd0;
    localparam logic [1:0]  CMD_MAC   = 2'd1;
    localparam logic [1:0]  CMD_SHIFT = 2'd2;
    localparam logic [1:0]  CMD_OUT   = 2'd3;
    localparam logic [AW:0] MAXN      = (AW+1)'(MAXTAPS);

    state_e        state_q, state_d;
    logic [AW-1:0] tap_q, tap_d, tap_nxt;
    logic [AW-1:0] last_tap_q, last_tap_d;
    logic [6:0]    shift_q, shift_d;
    logic [DW-1:0] x_q [MAXTAPS];
    logic [DW-1:0] c_q [MAXTAPS];

    logic          push_q, push_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] h_q, h_d;
    logic          done_q, done_d;

    logic          accept;
    logic          cfg_wr;
    logic [AW:0]   n_eff;
    logic [DW-1:0] c0_byp;

    assign s_ready = (state_q == IDLE) || (state_q == FLUSH);
    assign cfg_rdy = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign accept  = s_valid && s_ready;
    assign cfg_wr  = cfg_we && cfg_rdy && ({1'b0, cfg_addr} < MAXN);
    assign tap_nxt = tap_q + 1'b1;

    // A write landing in the accept cycle must already be seen by the first product.
    assign c0_byp  = (cfg_wr && (cfg_addr == '0)) ? cfg_data : c_q[0];

    always_comb begin
        if (ntaps == '0)
            n_eff = (AW+1)'(1);
        else if (ntaps > MAXN)
            n_eff = MAXN;
        else
            n_eff = ntaps;
    end

    // NOTE: every signal gets its default first so no path through the case leaves a latch.
    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        last_tap_d = last_tap_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
        cmd_d      = CMD_MULT;
        q_d        = '0;
        h_d        = '0;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: ;
            MAC: begin
                push_d = 1'b1;
                if (tap_q == last_tap_q) begin
                    state_d = SHIFT;
                    cmd_d   = CMD_SHIFT;
                    h_d     = DW'(shift_q);
                end else begin
                    tap_d = tap_nxt;
                    cmd_d = CMD_MAC;
                    q_d   = x_q[tap_nxt];
                    h_d   = c_q[tap_nxt];
                end
            end
            SHIFT: begin
                state_d = FLUSH;
                push_d  = 1'b1;
                cmd_d   = CMD_OUT;
                done_d  = 1'b1;
            end
            FLUSH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Accept overrides the IDLE/FLUSH exit so back-to-back bursts run without a gap.
        if (accept) begin
            state_d    = MAC;
            tap_d      = '0;
            last_tap_d = AW'(n_eff - 1'b1);
            shift_d    = shift;
            push_d     = 1'b1;
            cmd_d      = CMD_MULT;
            q_d        = s_data;
            h_d        = c0_byp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the delay line and
    // coefficient table are reset here as well because stale taps must read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            last_tap_q <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            cmd_q      <= '0;
            q_q        <= '0;
            h_q        <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < MAXTAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            last_tap_q <= last_tap_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            cmd_q      <= cmd_d;
            q_q        <= q_d;
            h_q        <= h_d;
            done_q     <= done_d;
            if (accept) begin
                x_q[0] <= s_data;
                for (int i = 1; i < MAXTAPS; i++)
                    x_q[i] <= x_q[i-1];
            end
            if (cfg_wr)
                c_q[cfg_addr] <= cfg_data;
        end
    end

    assign f_push = push_q;
    assign f_cmd  = cmd_q;
    assign f_q    = q_q;
    assign f_h    = h_q;
    assign done   = done_q;

endmodule
